// File: rtl/amm_burst_slave_mem.sv
// Avalon-MM burst slave backed by a word-addressed internal memory.
// Accepts write and read bursts with byteenable and returns read data after
// a fixed latency. Optional LFSR-driven waitrequest stalls. A sticky flag
// records protocol misuse by the master.
module amm_burst_slave_mem #(
    parameter int          ADDR_W       = 10,
    parameter int          DATA_W       = 32,
    parameter int          BURST_W      = 11,
    parameter int          READ_LATENCY = 2,
    parameter int          WAIT_EN      = 0,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   address,
    input  logic                read,
    input  logic                write,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic [BURST_W-1:0]  burstcount,
    input  logic [DATA_W-1:0]   writedata,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic                waitrequest,
    output logic                protocol_err
);

    localparam int NBYTES = DATA_W / 8;
    localparam int LAT_W  = 4;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_WAIT  = 2'd2,
        RD_DATA  = 2'd3
    } state_t;

    // 16-bit Fibonacci LFSR, taps 16/14/13/11 (maximal length).
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        lfsr_step = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    state_t              state_r;
    logic [ADDR_W-1:0]   wr_addr_r;
    logic [ADDR_W-1:0]   rd_addr_r;
    logic [BURST_W-1:0]  wr_rem_r;
    logic [BURST_W-1:0]  rd_cnt_r;
    logic [LAT_W-1:0]    lat_cnt_r;
    logic [15:0]         lfsr_r;
    logic                waitrequest_r;
    logic                readdatavalid_r;
    logic [DATA_W-1:0]   readdata_r;
    logic                protocol_err_r;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [15:0]         lfsr_next_s;
    logic                stall_s;
    logic                wr_acc_s;
    logic                rd_acc_s;
    logic                bc_zero_s;
    logic                mem_we_s;
    logic [ADDR_W-1:0]   mem_waddr_s;

    // Accept decode, stall bit and memory write port selection.
    always_comb begin
        lfsr_next_s = lfsr_step(lfsr_r);
        stall_s     = (WAIT_EN != 0) ? lfsr_next_s[0] : 1'b0;
        wr_acc_s    = write & ~waitrequest_r;
        rd_acc_s    = read & ~write & ~waitrequest_r;
        bc_zero_s   = (burstcount == {BURST_W{1'b0}});
        mem_we_s    = 1'b0;
        mem_waddr_s = address;
        case (state_r)
            IDLE: begin
                if (wr_acc_s) begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = address;
                end else begin
                    mem_we_s    = 1'b0;
                end
            end
            WR_BURST: begin
                if (wr_acc_s) begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = wr_addr_r;
                end else begin
                    mem_we_s    = 1'b0;
                end
            end
            default: begin
                mem_we_s = 1'b0;
            end
        endcase
    end

    // Byte-lane masked memory write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (byteenable[i]) begin
                    mem[mem_waddr_s][i*8 +: 8] <= writedata[i*8 +: 8];
                end
            end
        end
    end

    // Protocol FSM with registered waitrequest/readdata/readdatavalid/error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= IDLE;
            wr_addr_r       <= {ADDR_W{1'b0}};
            rd_addr_r       <= {ADDR_W{1'b0}};
            wr_rem_r        <= {BURST_W{1'b0}};
            rd_cnt_r        <= {BURST_W{1'b0}};
            lat_cnt_r       <= {LAT_W{1'b0}};
            lfsr_r          <= LFSR_SEED;
            waitrequest_r   <= 1'b1;
            readdatavalid_r <= 1'b0;
            readdata_r      <= {DATA_W{1'b0}};
            protocol_err_r  <= 1'b0;
        end else begin
            lfsr_r          <= lfsr_next_s;
            readdatavalid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    waitrequest_r <= stall_s;
                    if (wr_acc_s) begin
                        // Beat 0 is written by the memory port this edge.
                        wr_addr_r <= address + ADDR_W'(1);
                        if (bc_zero_s || read) begin
                            protocol_err_r <= 1'b1;
                        end
                        if (burstcount > BURST_W'(1)) begin
                            wr_rem_r <= burstcount - BURST_W'(1);
                            state_r  <= WR_BURST;
                        end
                    end else if (rd_acc_s) begin
                        rd_addr_r     <= address;
                        rd_cnt_r      <= bc_zero_s ? BURST_W'(1) : burstcount;
                        lat_cnt_r     <= (READ_LATENCY > 1) ? LAT_W'(READ_LATENCY - 2)
                                                            : {LAT_W{1'b0}};
                        waitrequest_r <= 1'b1;
                        state_r       <= (READ_LATENCY == 1) ? RD_DATA : RD_WAIT;
                        if (bc_zero_s) begin
                            protocol_err_r <= 1'b1;
                        end
                    end
                end
                WR_BURST: begin
                    waitrequest_r <= stall_s;
                    if (read) begin
                        protocol_err_r <= 1'b1;
                    end
                    if (wr_acc_s) begin
                        wr_addr_r <= wr_addr_r + ADDR_W'(1);
                        wr_rem_r  <= wr_rem_r - BURST_W'(1);
                        if (wr_rem_r == BURST_W'(1)) begin
                            state_r <= IDLE;
                        end
                    end
                end
                RD_WAIT: begin
                    waitrequest_r <= 1'b1;
                    if (lat_cnt_r == {LAT_W{1'b0}}) begin
                        state_r <= RD_DATA;
                    end else begin
                        lat_cnt_r <= lat_cnt_r - LAT_W'(1);
                    end
                end
                RD_DATA: begin
                    // Stay stalled through the final valid cycle; IDLE then
                    // lets waitrequest follow the stall bit.
                    waitrequest_r   <= 1'b1;
                    readdatavalid_r <= 1'b1;
                    readdata_r      <= mem[rd_addr_r];
                    rd_addr_r       <= rd_addr_r + ADDR_W'(1);
                    rd_cnt_r        <= rd_cnt_r - BURST_W'(1);
                    if (rd_cnt_r == BURST_W'(1)) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    waitrequest_r <= 1'b1;
                    state_r       <= IDLE;
                end
            endcase
        end
    end

    assign readdata      = readdata_r;
    assign readdatavalid = readdatavalid_r;
    assign waitrequest   = waitrequest_r;
    assign protocol_err  = protocol_err_r;

endmodule

// File: tb/tb_amm_burst_slave_mem.sv
// Bench for amm_burst_slave_mem: one instance without stalls (latency 2)
// and one with LFSR stalls (latency 3). Expected read beats are queued at
// stimulus time and popped by a monitor whenever readdatavalid is seen.
module tb_amm_burst_slave_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v     [2];
    logic [9:0]  address_v [2];
    logic        read_v    [2];
    logic        write_v   [2];
    logic [3:0]  be_v      [2];
    logic [10:0] bc_v      [2];
    logic [31:0] wd_v      [2];

    logic [31:0] rdata0, rdata1;
    logic        rdv0, rdv1, wreq0, wreq1, perr0, perr1;

    amm_burst_slave_mem #(
        .ADDR_W(10), .DATA_W(32), .BURST_W(11),
        .READ_LATENCY(2), .WAIT_EN(0), .LFSR_SEED(16'hACE1)
    ) dut0 (
        .clk(clk), .rst(rst_v[0]), .address(address_v[0]), .read(read_v[0]),
        .write(write_v[0]), .byteenable(be_v[0]), .burstcount(bc_v[0]),
        .writedata(wd_v[0]), .readdata(rdata0), .readdatavalid(rdv0),
        .waitrequest(wreq0), .protocol_err(perr0)
    );

    amm_burst_slave_mem #(
        .ADDR_W(10), .DATA_W(32), .BURST_W(11),
        .READ_LATENCY(3), .WAIT_EN(1), .LFSR_SEED(16'hACE1)
    ) dut1 (
        .clk(clk), .rst(rst_v[1]), .address(address_v[1]), .read(read_v[1]),
        .write(write_v[1]), .byteenable(be_v[1]), .burstcount(bc_v[1]),
        .writedata(wd_v[1]), .readdata(rdata1), .readdatavalid(rdv1),
        .waitrequest(wreq1), .protocol_err(perr1)
    );

    int total = 0;
    int bad   = 0;
    int vcnt0 = 0;
    int vcnt1 = 0;
    int stall_cnt = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void chk1(string name, logic act, logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endfunction

    function automatic void push(int s, logic [31:0] v);
        if (s == 0) q0.push_back(v);
        else        q1.push_back(v);
    endfunction

    // Monitor: every valid read beat must match the head of its queue.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rdv0 === 1'b1) begin
            vcnt0++;
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL rdv_unexpected0: got readdata %h expected no beat", rdata0);
            end else begin
                e = q0.pop_front();
                chk("rdata0", rdata0, e);
            end
        end
        if (rdv1 === 1'b1) begin
            vcnt1++;
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL rdv_unexpected1: got readdata %h expected no beat", rdata1);
            end else begin
                e = q1.pop_front();
                chk("rdata1", rdata1, e);
            end
        end
    end

    // One command/beat; holds it until the slave accepts it (bounded).
    task automatic beat(input int s, input logic wr, input logic rd, input logic [9:0] a,
                        input logic [10:0] bc, input logic [31:0] d, input logic [3:0] be);
        int   n;
        logic st;
        write_v[s] = wr; read_v[s] = rd; address_v[s] = a;
        bc_v[s] = bc; wd_v[s] = d; be_v[s] = be;
        n = 0;
        do begin
            @(negedge clk);
            st = (s == 0) ? wreq0 : wreq1;
            if (st && wr && s == 1) stall_cnt++;
            @(posedge clk);
            n++;
        end while (st && n < 200);
        chk1("accept", st, 1'b0);
        #1;
        write_v[s] = 1'b0;
        read_v[s]  = 1'b0;
    endtask

    task automatic wr(input int s, input logic [9:0] a, input logic [10:0] bc,
                      input logic [31:0] d, input logic [3:0] be);
        beat(s, 1'b1, 1'b0, a, bc, d, be);
    endtask

    task automatic rd(input int s, input logic [9:0] a, input logic [10:0] bc);
        beat(s, 1'b0, 1'b1, a, bc, 32'd0, 4'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int base;
        for (int s = 0; s < 2; s++) begin
            rst_v[s] = 1'b1; address_v[s] = 10'd0; read_v[s] = 1'b0; write_v[s] = 1'b0;
            be_v[s] = 4'd0; bc_v[s] = 11'd0; wd_v[s] = 32'd0;
        end

        // Reset state
        @(negedge clk);
        chk1("rst_wreq0", wreq0, 1'b1);
        chk1("rst_rdv0", rdv0, 1'b0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk1("rst_perr0", perr0, 1'b0);
        chk1("rst_wreq1", wreq1, 1'b1);
        chk1("rst_rdv1", rdv1, 1'b0);
        @(posedge clk); #1;
        rst_v[0] = 1'b0; rst_v[1] = 1'b0;
        idle(2);

        // T1: single write then read, exact latency and waitrequest window
        wr(0, 10'd5, 11'd1, 32'hDEADBEEF, 4'hF);
        push(0, 32'hDEADBEEF);
        rd(0, 10'd5, 11'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk1("t1_rdv", rdv0, (k == 2));
            chk1("t1_wreq", wreq0, (k <= 2));
        end
        chk("t1_hold", rdata0, 32'hDEADBEEF);
        idle(1);

        // T2: burst of 4 with a master pause; later beats carry junk addr/bc
        wr(0, 10'd16, 11'd4, 32'd1, 4'hF);
        wr(0, 10'h3FF, 11'd0, 32'd2, 4'hF);
        idle(1);
        wr(0, 10'h3FF, 11'd0, 32'd3, 4'hF);
        wr(0, 10'h3FF, 11'd0, 32'd4, 4'hF);
        for (int i = 1; i <= 4; i++) push(0, 32'(i));
        rd(0, 10'd16, 11'd4);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk1("t2_gapless", rdv0, 1'b1);
        end
        idle(3);
        chk1("t2_perr", perr0, 1'b0);

        // T3: byteenable lanes 0 and 2 only
        wr(0, 10'd7, 11'd1, 32'hFFFFFFFF, 4'hF);
        wr(0, 10'd7, 11'd1, 32'h11223344, 4'b0101);
        push(0, 32'hFF22FF44);
        rd(0, 10'd7, 11'd1);
        idle(6);

        // T4: wrap at top of memory, then protocol errors
        wr(0, 10'd1023, 11'd3, 32'hA0, 4'hF);
        wr(0, 10'd0, 11'd0, 32'hA1, 4'hF);
        wr(0, 10'd0, 11'd0, 32'hA2, 4'hF);
        push(0, 32'hA0); push(0, 32'hA1); push(0, 32'hA2);
        rd(0, 10'd1023, 11'd3);
        idle(8);
        push(0, 32'hA1);
        rd(0, 10'd0, 11'd1);
        idle(6);
        chk1("t4_perr_clean", perr0, 1'b0);
        wr(0, 10'd50, 11'd0, 32'h55, 4'hF);
        idle(1);
        chk1("t4_perr_bc0", perr0, 1'b1);
        wr(0, 10'd51, 11'd1, 32'h66, 4'hF);
        beat(0, 1'b1, 1'b1, 10'd60, 11'd1, 32'h77, 4'hF);
        idle(12);
        push(0, 32'h55); push(0, 32'h66);
        rd(0, 10'd50, 11'd2);
        idle(6);
        push(0, 32'h77);
        rd(0, 10'd60, 11'd1);
        idle(6);
        chk1("t4_perr_sticky", perr0, 1'b1);

        // T5: reset in the middle of a read burst of 8
        for (int i = 0; i < 8; i++) wr(0, 10'd100, 11'd8, 32'hB0000000 + 32'(i), 4'hF);
        for (int i = 0; i < 3; i++) push(0, 32'hB0000000 + 32'(i));
        base = vcnt0;
        rd(0, 10'd100, 11'd8);
        n = 0;
        while (vcnt0 < base + 3 && n < 40) begin
            @(negedge clk); #2;
            n++;
        end
        chk("t5_beats_before_rst", 32'(vcnt0 - base), 32'd3);
        rst_v[0] = 1'b1;
        #1;
        chk1("t5_rdv_at_rst", rdv0, 1'b0);
        chk1("t5_wreq_at_rst", wreq0, 1'b1);
        repeat (2) @(negedge clk);
        chk1("t5_rdv_in_rst", rdv0, 1'b0);
        chk1("t5_perr_cleared", perr0, 1'b0);
        chk("t5_rdata_cleared", rdata0, 32'd0);
        @(posedge clk); #1;
        rst_v[0] = 1'b0;
        idle(2);
        push(0, 32'hB0000005);
        rd(0, 10'd105, 11'd1);
        idle(6);

        // T6: stall-enabled instance, burst 16 write and read back
        stall_cnt = 0;
        for (int i = 0; i < 16; i++) wr(1, 10'd200, 11'd16, 32'hC0000000 + 32'(i), 4'hF);
        chk1("t6_saw_stall", (stall_cnt > 0), 1'b1);
        for (int i = 0; i < 16; i++) push(1, 32'hC0000000 + 32'(i));
        rd(1, 10'd200, 11'd16);
        idle(30);
        chk1("t6_perr", perr1, 1'b0);

        // Drain
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/amm_burst_slave_mem.md
Name: amm_burst_slave_mem

Overview:
- Avalon-MM burst slave with an internal word-addressed memory.
- Sits on the slave modport of the team's Avalon-MM interface and serves the memory checker's master as the memory under test in the testbench.
- Accepts write and read bursts, honours byteenable and returns read data with a configurable fixed latency.
- Optional pseudo-random waitrequest insertion and a sticky protocol-error flag.

Parameters:
ADDR_W, 10, word address width; memory depth = 2**ADDR_W words
DATA_W, 32, data width in bits; multiple of 8
BURST_W, 11, burstcount width
READ_LATENCY, 2, cycles from read-command acceptance to first readdatavalid; legal range 1..8
WAIT_EN, 0, 1 = insert LFSR-driven waitrequest stalls in IDLE/WR_BURST
LFSR_SEED, 16'hACE1, seed of the 16-bit stall LFSR

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
address  input  ADDR_W  word address; sampled on first beat only
read  input  1  read command
write  input  1  write beat
byteenable  input  DATA_W/8  byte lanes for write beats
burstcount  input  BURST_W  burst length; sampled on first beat only
writedata  input  DATA_W  write data
readdata  output  DATA_W  read data
readdatavalid  output  1  readdata valid
waitrequest  output  1  stall; registered, no combinational path from inputs
protocol_err  output  1  sticky protocol-violation flag

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values while rst=1: waitrequest=1, readdatavalid=0, readdata=0, protocol_err=0, state=IDLE, LFSR=LFSR_SEED. Memory contents are not reset.
- Accept condition: a beat or command is accepted at a rising edge where (write or read)=1 and waitrequest=0.
- Stall bit: next LFSR bit when WAIT_EN=1, otherwise 0.
- States:
  - IDLE: waitrequest = stall bit.
    - write accepted: write beat 0 at address; latch addr+1 and remaining = burstcount-1; go to WR_BURST if remaining>0, else stay in IDLE.
    - read accepted (write=0): latch address, count = burstcount, latency counter; go to RD_WAIT.
  - WR_BURST: waitrequest = stall bit.
    - Each accepted write beat writes mem[addr] under byteenable, then addr+1 and remaining-1.
    - A cycle with write=0 is a master pause and changes no state.
    - Return to IDLE after the beat with remaining=1.
  - RD_WAIT: waitrequest=1. Counts READ_LATENCY-1 cycles, then goes to RD_DATA; goes directly to RD_DATA when READ_LATENCY=1.
  - RD_DATA: waitrequest=1. Each cycle readdatavalid=1 and readdata=mem[addr]; addr+1, count-1. After the last beat go to IDLE; waitrequest follows the stall bit from the next cycle.
- Timing: command accepted at edge N gives beat k (k=0..B-1) valid in the cycle after edge N+READ_LATENCY+k. No gaps between beats. One outstanding read burst at a time.
- Byteenable: byte i of the word is written only if byteenable[i]=1. A beat with all-zero byteenable writes nothing but still counts as a beat.
- Address arithmetic: modulo 2**ADDR_W; a burst wraps from the last word to word 0.
- burstcount=0 on a first beat: treated as 1, and protocol_err is set.
- read=1 and write=1 together in IDLE: write takes priority, the read is ignored, protocol_err is set.
- read=1 during WR_BURST: ignored, protocol_err is set.
- protocol_err clears only on rst.
- readdata holds its last value when readdatavalid=0.
- LFSR advances every cycle out of reset, independent of traffic.
- Reset mid-burst: any burst is aborted immediately. No further readdatavalid. Memory words already written stay written.

Test Plan:
- Single write then read, READ_LATENCY=2, WAIT_EN=0: write addr 5, data 32'hDEADBEEF, byteenable 4'hF, burstcount 1; then read addr 5, burstcount 1 accepted at edge N -> readdatavalid=1 for one cycle after edge N+2, readdata 32'hDEADBEEF; waitrequest=1 from the cycle after acceptance through that valid cycle.
- Burst: write burstcount 4 at addr 16, data 1,2,3,4, with one write=0 pause cycle after beat 1; then read burst 4 -> four consecutive valid beats 1,2,3,4; protocol_err=0.
- Byteenable: write 32'hFFFFFFFF to addr 7, then 32'h11223344 with byteenable 4'b0101 -> read returns 32'hFF22FF44.
- Wrap and protocol errors: write burst 3 at addr 1023 (ADDR_W=10) -> words 1023, 0, 1 written. Issue burstcount 0 -> single beat written and protocol_err=1. Assert read and write together -> write done, no read data returned.
- Reset mid-read and stalls: start read burst 8, assert rst after 3 valid beats -> readdatavalid=0 and waitrequest=1 immediately; after release, a new single read succeeds. With WAIT_EN=1, write burst 16 then read it back -> all data matches and waitrequest shows at least one stall cycle.
